rxe_fcs_check: RTL and testbench



---
 rtl/rxe_fcs_check.sv | 146 ++++++++++++++
 tb/tb_rxe_fcs_check.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxe_fcs_check.sv
// rxe_fcs_check
// Receive-path FCS checker that sits just before the memory-write stage.
// It runs CRC-32 over every received frame, including the FCS bytes.
// When OPT_STRIP=1 it delays the stream by four bytes, so the trailing FCS
// never reaches the writer. At the end of each frame it reports the frame
// length and whether the frame was bad: a CRC mismatch or a runt.
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_v, i_d   input byte stream; i_v is contiguous per frame and idles
//              for at least one cycle between frames
//   o_v, o_d   output byte stream, same convention as the input
//   o_done     one-cycle end-of-frame pulse
//   o_err      bad FCS or runt, qualified by o_done
//   o_len      bytes received including FCS, qualified by o_done
module rxe_fcs_check #(
    parameter bit OPT_STRIP = 1'b1,
    parameter int LGLEN     = 14
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_v,
    input  logic [7:0]       i_d,
    output logic             o_v,
    output logic [7:0]       o_d,
    output logic             o_done,
    output logic             o_err,
    output logic [LGLEN-1:0] o_len
);

    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LGLEN-1:0] CNT_MAX     = '1;
    localparam logic [LGLEN-1:0] CNT_FCS     = LGLEN'(4);
    localparam logic [LGLEN-1:0] CNT_MIN     = LGLEN'(5);

    // Reflected CRC-32 update over one byte.
    // The byte is consumed LSB first.
    function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    logic             armed_q, armed_d;
    logic             prev_v_q, prev_v_d;
    logic [31:0]      crc_q, crc_d;
    logic [LGLEN-1:0] count_q, count_d;
    logic [3:0][7:0]  dly_q, dly_d;
    logic             ov_q, ov_d;
    logic [7:0]       od_q, od_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LGLEN-1:0] len_q, len_d;

    logic accept;
    logic eof;

    // Input is accepted only after the first idle cycle seen since reset.
    // As a result, a frame that is already in flight when reset releases is
    // dropped as a whole.
    // End of frame is the first idle cycle after accepted bytes. It can never
    // coincide with an accepted byte, so clearing the CRC and count here
    // cannot clobber byte 0 of the following frame.
    always_comb begin
        accept   = armed_q & i_v;
        eof      = armed_q & ~i_v & prev_v_q;

        armed_d  = armed_q | ~i_v;
        prev_v_d = accept;
        crc_d    = crc_q;
        count_d  = count_q;
        dly_d    = dly_q;
        ov_d     = 1'b0;
        od_d     = od_q;
        done_d   = eof;
        err_d    = 1'b0;
        len_d    = len_q;

        if (accept) begin
            crc_d   = crcByte(crc_q, i_d);
            count_d = (count_q == CNT_MAX) ? count_q : count_q + LGLEN'(1);
            dly_d   = {dly_q[2:0], i_d};
        end else if (eof) begin
            crc_d   = CRC_INIT;
            count_d = '0;
            err_d   = (crc_q != CRC_RESIDUE) || (count_q < CNT_MIN);
            len_d   = count_q;
        end

        // With stripping on, a byte is released only once four newer bytes
        // have arrived behind it. The final four bytes of a frame are the
        // FCS, and they are therefore never released.
        if (OPT_STRIP) begin
            ov_d = accept && (count_q >= CNT_FCS);
            if (ov_d) begin
                od_d = dly_q[3];
            end
        end else begin
            ov_d = accept;
            if (accept) begin
                od_d = i_d;
            end
        end
    end

    // State and output registers.
    // Reset is asynchronous, so an aborted frame clears its outputs at once.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed_q  <= 1'b0;
            prev_v_q <= 1'b0;
            crc_q    <= CRC_INIT;
            count_q  <= '0;
            dly_q    <= '0;
            ov_q     <= 1'b0;
            od_q     <= 8'h00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            len_q    <= '0;
        end else begin
            armed_q  <= armed_d;
            prev_v_q <= prev_v_d;
            crc_q    <= crc_d;
            count_q  <= count_d;
            dly_q    <= dly_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
            done_q   <= done_d;
            err_q    <= err_d;
            len_q    <= len_d;
        end
    end

    assign o_v    = ov_q;
    assign o_d    = od_q;
    assign o_done = done_q;
    assign o_err  = err_q;
    assign o_len  = len_q;

endmodule

// File: tb/tb_rxe_fcs_check.sv
// Testbench for rxe_fcs_check.
// Three instances share one input stream:
//   dutS  - stripping on, default length width
//   dutN  - stripping off
//   dutT  - stripping on, 4-bit length counter, used to exercise saturation
// Expected bytes and end-of-frame results are queued when stimulus is driven
// and popped when the corresponding DUT produces them.
module tb_rxe_fcs_check;

    typedef struct packed {
        logic [23:0][7:0] data;
        int               n;
        logic             expErr;
        int               expLen;
        int               gap;
    } vec_t;

    typedef struct packed {
        logic err;
        int   len;
    } done_t;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_v;
    logic [7:0]  i_d;

    logic        sV, nV, tV;
    logic [7:0]  sD, nD, tD;
    logic        sDone, nDone, tDone;
    logic        sErr, nErr, tErr;
    logic [13:0] sLen, nLen;
    logic [3:0]  tLen;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] expS[$];
    logic [7:0] expN[$];
    done_t      doneS[$];
    done_t      doneN[$];
    done_t      doneT[$];

    vec_t vecs[8];

    rxe_fcs_check #(.OPT_STRIP(1'b1), .LGLEN(14)) dutS (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_v(i_v), .i_d(i_d),
        .o_v(sV), .o_d(sD), .o_done(sDone), .o_err(sErr), .o_len(sLen)
    );

    rxe_fcs_check #(.OPT_STRIP(1'b0), .LGLEN(14)) dutN (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_v(i_v), .i_d(i_d),
        .o_v(nV), .o_d(nD), .o_done(nDone), .o_err(nErr), .o_len(nLen)
    );

    rxe_fcs_check #(.OPT_STRIP(1'b1), .LGLEN(4)) dutT (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_v(i_v), .i_d(i_d),
        .o_v(tV), .o_d(tD), .o_done(tDone), .o_err(tErr), .o_len(tLen)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Any single comparison funnels through here so counts stay consistent
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference FCS: bit-serial CRC-32 over the payload, complemented
    function automatic logic [31:0] fcsOf(input logic [23:0][7:0] data, input int n);
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ data[k][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        return ~crc;
    endfunction

    task automatic driveByte(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_v = 1'b1;
        i_d = b;
    endtask

    task automatic driveIdle();
        @(posedge i_clk);
        #1;
        i_v = 1'b0;
    endtask

    // Drive one frame, queue what every DUT should emit, then idle for gap cycles
    task automatic applyStimulus(input vec_t v);
        done_t d;
        for (int k = 0; k < v.n; k++) begin
            driveByte(v.data[k]);
            expN.push_back(v.data[k]);
            if (k >= 4) expS.push_back(v.data[k-4]);
        end
        d.err = v.expErr;
        d.len = v.expLen;
        doneS.push_back(d);
        doneN.push_back(d);
        d.len = (v.expLen > 15) ? 15 : v.expLen;
        doneT.push_back(d);
        for (int g = 0; g < v.gap; g++) driveIdle();
    endtask

    // Stripping instance: bytes and end-of-frame
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (sV) begin
                if (expS.size() == 0) checkOutput("strip_unexpected_ov", 1, 0);
                else checkOutput("strip_od", int'(sD), int'(expS.pop_front()));
            end
            if (sDone) begin
                checkOutput("strip_ov_with_done", int'(sV), 0);
                if (doneS.size() == 0) checkOutput("strip_unexpected_done", 1, 0);
                else begin
                    done_t d;
                    d = doneS.pop_front();
                    checkOutput("strip_err", int'(sErr), int'(d.err));
                    checkOutput("strip_len", int'(sLen), d.len);
                end
            end
        end
    end

    // Pass-through instance: bytes and end-of-frame
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (nV) begin
                if (expN.size() == 0) checkOutput("pass_unexpected_ov", 1, 0);
                else checkOutput("pass_od", int'(nD), int'(expN.pop_front()));
            end
            if (nDone) begin
                checkOutput("pass_ov_with_done", int'(nV), 0);
                if (doneN.size() == 0) checkOutput("pass_unexpected_done", 1, 0);
                else begin
                    done_t d;
                    d = doneN.pop_front();
                    checkOutput("pass_err", int'(nErr), int'(d.err));
                    checkOutput("pass_len", int'(nLen), d.len);
                end
            end
        end
    end

    // Narrow-counter instance: only its end-of-frame results are scored
    always @(negedge i_clk) begin
        if (i_reset_n && tDone) begin
            if (doneT.size() == 0) checkOutput("sat_unexpected_done", 1, 0);
            else begin
                done_t d;
                d = doneT.pop_front();
                checkOutput("sat_err", int'(tErr), int'(d.err));
                checkOutput("sat_len", int'(tLen), d.len);
            end
        end
    end

    // Global bound so a stuck bench still terminates
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ov"},   int'(sV), 0);
        checkOutput({tag, "_s_od"},   int'(sD), 0);
        checkOutput({tag, "_s_done"}, int'(sDone), 0);
        checkOutput({tag, "_s_err"},  int'(sErr), 0);
        checkOutput({tag, "_s_len"},  int'(sLen), 0);
        checkOutput({tag, "_n_ov"},   int'(nV), 0);
        checkOutput({tag, "_n_od"},   int'(nD), 0);
        checkOutput({tag, "_n_done"}, int'(nDone), 0);
        checkOutput({tag, "_t_len"},  int'(tLen), 0);
    endtask

    initial begin
        vec_t        t;
        logic [31:0] f;

        // Good "123456789" frame with its known FCS
        t = '0;
        for (int k = 0; k < 9; k++) t.data[k] = 8'h31 + 8'(k);
        t.data[9] = 8'h26; t.data[10] = 8'h39; t.data[11] = 8'hF4; t.data[12] = 8'hCB;
        t.n = 13; t.expErr = 1'b0; t.expLen = 13; t.gap = 1;
        vecs[0] = t;
        // Same frame with byte 3 corrupted
        t.data[3] = 8'h35; t.expErr = 1'b1;
        vecs[1] = t;
        // Runt of three bytes
        t = '0;
        t.data[0] = 8'hAA; t.data[1] = 8'hBB; t.data[2] = 8'hCC;
        t.n = 3; t.expErr = 1'b1; t.expLen = 3; t.gap = 2;
        vecs[2] = t;
        // FCS only (empty payload has FCS 00000000): CRC matches but still a runt
        t = '0;
        t.n = 4; t.expErr = 1'b1; t.expLen = 4; t.gap = 1;
        vecs[3] = t;
        // Shortest legal frame: one payload byte plus FCS
        t = '0;
        t.data[0] = 8'h5A;
        f = fcsOf(t.data, 1);
        t.data[1] = f[7:0]; t.data[2] = f[15:8]; t.data[3] = f[23:16]; t.data[4] = f[31:24];
        t.n = 5; t.expErr = 1'b0; t.expLen = 5; t.gap = 1;
        vecs[4] = t;
        // Good frame sent back-to-back after a single idle cycle
        vecs[5] = vecs[0];
        // Random 16-byte payload; 20 bytes saturates the 4-bit counter
        t = '0;
        for (int k = 0; k < 16; k++) t.data[k] = 8'($urandom_range(0, 255));
        f = fcsOf(t.data, 16);
        t.data[16] = f[7:0]; t.data[17] = f[15:8]; t.data[18] = f[23:16]; t.data[19] = f[31:24];
        t.n = 20; t.expErr = 1'b0; t.expLen = 20; t.gap = 3;
        vecs[6] = t;
        vecs[7] = vecs[0];
        vecs[7].gap = 2;

        i_reset_n = 1'b0;
        i_v = 1'b0;
        i_d = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        checkAllZero("reset");
        i_reset_n = 1'b1;
        driveIdle();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Async reset in the middle of a frame, released while i_v is still high
        for (int k = 0; k < 4; k++) begin
            driveByte(vecs[0].data[k]);
            expN.push_back(vecs[0].data[k]);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        expS.delete(); expN.delete();
        doneS.delete(); doneN.delete(); doneT.delete();
        driveByte(vecs[0].data[4]);
        #3;
        i_reset_n = 1'b1;
        for (int k = 5; k < 13; k++) driveByte(vecs[0].data[k]);
        driveIdle();
        driveIdle();
        applyStimulus(vecs[0]);

        // Drain with a bounded wait, then require every expectation consumed
        for (int c = 0; c < 60; c++) begin
            if (expS.size() == 0 && expN.size() == 0 && doneS.size() == 0 &&
                doneN.size() == 0 && doneT.size() == 0) break;
            @(posedge i_clk);
        end
        repeat (2) @(posedge i_clk);
        checkOutput("drain_strip_bytes", expS.size(), 0);
        checkOutput("drain_pass_bytes",  expN.size(), 0);
        checkOutput("drain_strip_done",  doneS.size(), 0);
        checkOutput("drain_pass_done",   doneN.size(), 0);
        checkOutput("drain_sat_done",    doneT.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
